addsub_chunked: RTL and testbench
=================================

Name: addsub_chunked

Overview:
- Parametrised multi-cycle two's-complement adder/subtractor, successor to the 4-bit M-controlled add/sub unit.
- Processes operands CHUNK bits per clock: ripple carry within a chunk, registered carry between chunks.
- Valid/ready handshake on both sides; produces carry, signed-overflow, zero and negative flags.
- Sits between operand-supply logic and a result consumer, where a WIDTH-bit single-cycle ripple path would fail timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be ≥ 2.
- CHUNK, 4, bits processed per BUSY cycle; WIDTH % CHUNK == 0 required (elaboration error otherwise).
- N (localparam), WIDTH/CHUNK, number of BUSY cycles per operation.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/mode present.
- in_ready  output  1  block can accept an operation.
- mode  input  1  0 = A+B, 1 = A−B (A + ~B + 1).
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  result and flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  sum/difference modulo 2^WIDTH.
- cout  output  1  final carry out; for subtract, 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  signed overflow.
- zero  output  1  result == 0.
- neg  output  1  result[WIDTH−1].

Behaviour:
- FSM states: IDLE, BUSY, DONE. All outputs are registered.
- Reset (rst=1 at an edge), regardless of state:
  - state→IDLE; in_ready=1; out_valid=0.
  - result, cout, ovf, zero, neg = 0; internal operand, carry and chunk-index registers = 0.
  - An operation in progress is abandoned; its result is never presented.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready at an edge:
    - capture A = a, B' = b ^ {WIDTH{mode}}, carry = mode, idx = 0.
    - state→BUSY; in_ready falls after this edge.
- BUSY:
  - Each edge processes chunk idx (bits idx·CHUNK+CHUNK−1 .. idx·CHUNK): {c, s} = A_chunk + B'_chunk + carry.
  - s is written into the corresponding result slice; carry ← c; idx ← idx+1.
  - At the edge with idx == N−1:
    - cout ← final carry.
    - ovf ← (A[MSB] == B'[MSB]) && (s_msb != A[MSB]).
    - zero ← (full result == 0), evaluated on the completed result including the slice written this edge.
    - neg ← result MSB.
    - state→DONE; out_valid rises after this edge.
  - in_valid is ignored in BUSY; in_ready=0.
- DONE:
  - out_valid=1; result and flags hold stable while out_ready=0, for any duration.
  - On out_valid && out_ready: state→IDLE; out_valid=0 and in_ready=1 after that edge.
  - No same-cycle accept of a new operation.
- Latency: out_valid asserts exactly N cycles after the accept edge.
- Throughput: one operation per N+2 cycles minimum with out_ready held high.
- result and flags change only at the final BUSY edge or on reset; they hold their last values in IDLE.
  - Exception: partial result slices update during BUSY; consumers must qualify with out_valid.
- CHUNK == WIDTH is legal: N=1, single BUSY cycle.
- mode, a and b are sampled only at the accept edge; later changes have no effect.

Test Plan:
- WIDTH=16, CHUNK=4: add 0x1234 + 0x0FFF.
  - Expect out_valid exactly 4 cycles after the accept edge.
  - Expect result=0x2233, cout=0, ovf=0, zero=0, neg=0.
- Subtract 0x0005 − 0x0007 → result=0xFFFE, cout=0 (borrow), neg=1, ovf=0, zero=0.
- Subtract 0x8000 − 0x0001 → result=0x7FFF, ovf=1, cout=1, neg=0.
- Add 0xFFFF + 0x0001 → result=0x0000, cout=1, zero=1, ovf=0.
  - Then add 0x7FFF + 0x0001 → result=0x8000, ovf=1, neg=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE → result and flags stable, in_ready=0.
  - Toggle in_valid with new operands during BUSY/DONE → ignored.
  - Release out_ready → in_ready=1 on the following cycle.
- Reset mid-operation:
  - Assert rst on the 2nd BUSY cycle → next cycle: in_ready=1, out_valid=0, all outputs 0.
  - Next operation (sub 0x0100 − 0x0001) → 0x00FF, cout=1.
  - Repeat with CHUNK=16 (N=1): latency 1 cycle.

Source files
------------

// File: rtl/addsub_chunked.sv
// addsub_chunked: multi-cycle two's-complement adder/subtractor.
// Operands are processed CHUNK bits per clock. The carry ripples inside a
// chunk and is registered between chunks, so the critical path is one
// CHUNK-bit adder rather than a WIDTH-bit ripple.
//
// Ports
//   clk, rst               clock, synchronous active-high reset
//   in_valid / in_ready    operand handshake (mode, a, b sampled at accept)
//   mode                   0 = a + b, 1 = a - b
//   out_valid / out_ready  result handshake
//   result                 sum/difference modulo 2^WIDTH
//   cout                   final carry (subtract: 1 = no borrow)
//   ovf, zero, neg         signed overflow, result == 0, result MSB

// One chunk of the ripple adder: {co, s} = x + y + ci.
module addsub_chunked_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);
    assign {co, s} = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
endmodule

module addsub_chunked #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    localparam int N  = WIDTH / CHUNK;
    localparam int IW = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || (WIDTH % CHUNK) != 0) begin : g_param_err
        $error("addsub_chunked: WIDTH must be >= 2 and a multiple of CHUNK");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;     // b_r already holds b ^ {WIDTH{mode}}
    logic             carry;
    logic [IW-1:0]    idx;
    logic [CHUNK-1:0] s;
    logic             c;
    logic             last;
    logic [WIDTH-1:0] res_nx;       // result with this edge's slice merged in

    addsub_chunked_slice #(.CHUNK(CHUNK)) u_slice (
        .x  (a_r[idx*CHUNK +: CHUNK]),
        .y  (b_r[idx*CHUNK +: CHUNK]),
        .ci (carry),
        .s  (s),
        .co (c)
    );

    assign last = (idx == IW'(N - 1));

    always_comb begin
        res_nx = result;
        res_nx[idx*CHUNK +: CHUNK] = s;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid)  state_nx = BUSY;
            BUSY:    if (last)      state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default:                state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            neg       <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    a_r      <= a;
                    b_r      <= b ^ {WIDTH{mode}};
                    carry    <= mode;   // the +1 of two's-complement negate
                    idx      <= '0;
                    in_ready <= 1'b0;
                end
                BUSY: begin
                    result <= res_nx;
                    carry  <= c;
                    idx    <= last ? '0 : idx + 1'b1;
                    if (last) begin
                        cout      <= c;
                        ovf       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (res_nx[WIDTH-1] != a_r[WIDTH-1]);
                        zero      <= (res_nx == '0);
                        neg       <= res_nx[WIDTH-1];
                        out_valid <= 1'b1;
                    end
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_addsub_chunked.sv
module tb_addsub_chunked;
    typedef struct {
        logic        mode;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic [3:0]  flg;   // {cout, ovf, zero, neg}
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;   // 0: CHUNK=4 instance, 1: CHUNK=16 instance

    logic        ir0, ov0, c0, v0, z0, n0;
    logic        ir1, ov1, c1, v1, z1, n1;
    logic [15:0] r0, r1;

    int n_app = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    addsub_chunked #(.WIDTH(16), .CHUNK(4)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid && !sel), .in_ready(ir0),
        .mode(mode), .a(a), .b(b), .out_valid(ov0), .out_ready(out_ready && !sel),
        .result(r0), .cout(c0), .ovf(v0), .zero(z0), .neg(n0)
    );

    addsub_chunked #(.WIDTH(16), .CHUNK(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid && sel), .in_ready(ir1),
        .mode(mode), .a(a), .b(b), .out_valid(ov1), .out_ready(out_ready && sel),
        .result(r1), .cout(c1), .ovf(v1), .zero(z1), .neg(n1)
    );

    wire        ir  = sel ? ir1 : ir0;
    wire        ov  = sel ? ov1 : ov0;
    wire [15:0] res = sel ? r1 : r0;
    wire [3:0]  flg = sel ? {c1, v1, z1, n1} : {c0, v0, z0, n0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_app++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one op, measure latency, check result/flags, then drain it.
    task automatic do_op(input vec_t v, input int lat, input string tag);
        int cnt;
        chk({tag, " in_ready idle"}, 32'(ir), 32'd1);
        mode = v.mode; a = v.a; b = v.b; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, " in_ready busy"}, 32'(ir), 32'd0);
        cnt = 0;
        while (!ov && cnt < 20) begin
            tick();
            cnt++;
        end
        chk({tag, " latency"}, 32'(cnt), 32'(lat));
        chk({tag, " result"}, 32'(res), 32'(v.res));
        chk({tag, " flags"}, 32'(flg), 32'(v.flg));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " drain in_ready"}, 32'(ir), 32'd1);
        chk({tag, " drain out_valid"}, 32'(ov), 32'd0);
    endtask

    vec_t tv[8];

    initial begin
        logic [15:0] hold_r;
        logic [3:0]  hold_f;
        int          cnt;

        tv[0] = '{1'b0, 16'h1234, 16'h0FFF, 16'h2233, 4'b0000};
        tv[1] = '{1'b1, 16'h0005, 16'h0007, 16'hFFFE, 4'b0001};
        tv[2] = '{1'b1, 16'h8000, 16'h0001, 16'h7FFF, 4'b1100};
        tv[3] = '{1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b1010};
        tv[4] = '{1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b0101};
        tv[5] = '{1'b1, 16'h0100, 16'h0001, 16'h00FF, 4'b1000};
        tv[6] = '{1'b1, 16'h1234, 16'h1234, 16'h0000, 4'b1010};
        tv[7] = '{1'b0, 16'h8000, 16'h8000, 16'h0000, 4'b1110};

        tick(); tick();
        rst = 1'b0;
        chk("reset in_ready", 32'(ir0), 32'd1);
        chk("reset out_valid", 32'(ov0), 32'd0);
        chk("reset outputs", {r0, 12'd0, c0, v0, z0, n0}, 32'd0);
        chk("reset n1 outputs", {r1, ir1, ov1, 10'd0, c1, v1, z1, n1}, 32'h00008000);

        for (int i = 0; i < 8; i++) do_op(tv[i], 4, $sformatf("c4 v%0d", i));

        // Backpressure: new operands during BUSY/DONE must be ignored.
        mode = 1'b0; a = 16'h1234; b = 16'h0FFF; in_valid = 1'b1;
        tick();
        cnt = 0;
        while (!ov0 && cnt < 20) begin
            in_valid = ~in_valid; a = 16'hAAAA ^ a; b = 16'h5555 ^ b; mode = ~mode;
            tick();
            cnt++;
        end
        chk("bp latency", 32'(cnt), 32'd4);
        hold_r = r0; hold_f = {c0, v0, z0, n0};
        chk("bp result", 32'(hold_r), 32'h2233);
        for (int k = 0; k < 5; k++) begin
            in_valid = ~in_valid; a = a + 16'd3;
            tick();
            chk("bp hold result", 32'(r0), 32'(16'h2233));
            chk("bp hold flags", 32'({c0, v0, z0, n0}), 32'(4'b0000));
            chk("bp hold state", {30'd0, ir0, ov0}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp release", {30'd0, ir0, ov0}, 32'd2);
        tick();
        chk("bp idle stays", {30'd0, ir0, ov0}, 32'd2);
        chk("bp idle result", 32'(r0), 32'(16'h2233));

        // Reset on the second BUSY cycle abandons the op.
        mode = 1'b0; a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid-rst state", {30'd0, ir0, ov0}, 32'd2);
        chk("mid-rst outputs", {r0, 12'd0, c0, v0, z0, n0}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("mid-rst no result", 32'(ov0), 32'd0);
        end
        do_op(tv[5], 4, "post-rst");

        // Single-chunk instance: N = 1.
        sel = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) do_op(tv[i], 1, $sformatf("c16 v%0d", i));
        mode = 1'b1; a = 16'h0100; b = 16'h0001; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("c16 rst", {r1, ir1, ov1, 10'd0, c1, v1, z1, n1}, 32'h00008000);
        do_op(tv[5], 1, "c16 post-rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_app, n_bad);
        $finish;
    end
endmodule
